// File: rtl/tx_resp_queue_pkg.sv
// tx_resp_queue_pkg: shared drain-FSM state encoding and timeout counter width helper
package tx_resp_queue_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, SEND = 2'b01, DRAIN = 2'b10} state_t;
    function automatic int tmr_width(input int ack_timeout);
        return $clog2(ack_timeout + 1);
    endfunction
endpackage

// File: rtl/tx_resp_fifo_mem.sv
// tx_resp_fifo_mem: circular byte buffer with a single/dual-byte write port and a head pop.
// Ports: CLK/RST; wr_data/wr_en single-byte push; wr_word/wr_word_en LSB-first two-byte push;
// rd_en pops the head; rd_data is the head entry; count/empty/full occupancy; ovf_err dropped-push pulse.
module tx_resp_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_en,
    input  logic [2*DATA_WIDTH-1:0] wr_word,
    input  logic                    wr_word_en,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [ADDR_WIDTH:0]     count,
    output logic                    empty,
    output logic                    full,
    output logic                    ovf_err
);
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] WORD_MAX = (ADDR_WIDTH + 1)'(DEPTH - 2);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr, rptr, wptr_nx;
    logic                  word_ok, byte_ok, drop;
    logic [ADDR_WIDTH:0]   push_n;

    // Space is judged on the registered count, so a same-cycle pop never makes room.
    assign word_ok = wr_word_en && (count <= WORD_MAX);
    assign byte_ok = wr_en && !wr_word_en && !full;
    assign drop    = (wr_en && (wr_word_en || full)) || (wr_word_en && !word_ok);
    assign push_n  = word_ok ? (ADDR_WIDTH + 1)'(2) : byte_ok ? (ADDR_WIDTH + 1)'(1) : '0;
    assign wptr_nx = wptr + ADDR_WIDTH'(1);
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign rd_data = mem[rptr];

    always_ff @(posedge CLK) begin
        if (word_ok) begin
            mem[wptr]    <= wr_word[DATA_WIDTH-1:0];
            mem[wptr_nx] <= wr_word[2*DATA_WIDTH-1:DATA_WIDTH];
        end else if (byte_ok) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            wptr    <= wptr + push_n[ADDR_WIDTH-1:0];
            rptr    <= rptr + ADDR_WIDTH'(rd_en);
            count   <= count + push_n - {{ADDR_WIDTH{1'b0}}, rd_en};
            ovf_err <= drop;
        end
    end
endmodule

// File: rtl/tx_resp_queue.sv
// tx_resp_queue: response byte queue draining into UART TX through a level valid/busy handshake.
// Ports: CLK/RST; wr_data/wr_en byte push; wr_word/wr_word_en LSB-first word push;
// tx_busy_sync synchronized UART busy; tx_p_data/tx_d_vld offered byte and level valid;
// count/empty/full occupancy; ovf_err dropped-push pulse; to_err ack-timeout discard pulse.
module tx_resp_queue
    import tx_resp_queue_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_en,
    input  logic [2*DATA_WIDTH-1:0] wr_word,
    input  logic                    wr_word_en,
    input  logic                    tx_busy_sync,
    output logic [DATA_WIDTH-1:0]   tx_p_data,
    output logic                    tx_d_vld,
    output logic [ADDR_WIDTH:0]     count,
    output logic                    empty,
    output logic                    full,
    output logic                    ovf_err,
    output logic                    to_err
);
    localparam int TW = tmr_width(ACK_TIMEOUT);

    state_t                state_q, state_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [DATA_WIDTH-1:0] data_d, head;
    logic                  vld_d, to_d, pop;

    tx_resp_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .CLK       (CLK),
        .RST       (RST),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .wr_word   (wr_word),
        .wr_word_en(wr_word_en),
        .rd_en     (pop),
        .rd_data   (head),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .ovf_err   (ovf_err)
    );

    // The head stays in the buffer while offered; it is popped only on ack or timeout.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        data_d  = tx_p_data;
        vld_d   = tx_d_vld;
        to_d    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty && !tx_busy_sync) begin
                data_d  = head;
                vld_d   = 1'b1;
                tmr_d   = '0;
                state_d = SEND;
            end
            SEND: if (tx_busy_sync) begin
                vld_d   = 1'b0;
                pop     = 1'b1;
                state_d = DRAIN;
            end else if (tmr_q == TW'(ACK_TIMEOUT)) begin
                vld_d   = 1'b0;
                pop     = 1'b1;
                to_d    = 1'b1;
                state_d = IDLE;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
            DRAIN: if (!tx_busy_sync) state_d = IDLE;
            default: begin
                vld_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            tx_p_data <= '0;
            tx_d_vld  <= 1'b0;
            to_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            tx_p_data <= data_d;
            tx_d_vld  <= vld_d;
            to_err    <= to_d;
        end
    end
endmodule

// File: tb/tb_tx_resp_queue.sv
// tb_tx_resp_queue: directed and randomized self-checking bench for tx_resp_queue
module tb_tx_resp_queue;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TO    = 15;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic [2*DW-1:0] wr_word = '0;
    logic          wr_word_en = 1'b0;
    logic          tx_busy_sync = 1'b0;
    logic [DW-1:0] tx_p_data;
    logic          tx_d_vld;
    logic [AW:0]   count;
    logic          empty, full, ovf_err, to_err;

    int vectors = 0, miscompares = 0;
    int ovf_seen = 0, to_seen = 0, vld_cycles = 0;

    tx_resp_queue #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .ACK_TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .wr_data(wr_data), .wr_en(wr_en), .wr_word(wr_word),
        .wr_word_en(wr_word_en), .tx_busy_sync(tx_busy_sync), .tx_p_data(tx_p_data),
        .tx_d_vld(tx_d_vld), .count(count), .empty(empty), .full(full),
        .ovf_err(ovf_err), .to_err(to_err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (ovf_err) ovf_seen++;
        if (to_err) to_seen++;
        if (tx_d_vld) vld_cycles++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic handshake(input logic [DW-1:0] exp, input string tag);
        int n = 0;
        while (!tx_d_vld && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_vld"}, 32'(tx_d_vld), 32'd1);
        check({tag, "_data"}, 32'(tx_p_data), 32'(exp));
        tx_busy_sync = 1'b1;
        tick();
        check({tag, "_ack"}, 32'(tx_d_vld), 32'd0);
        tx_busy_sync = 1'b0;
        tick();
    endtask

    logic [DW-1:0] q[$];
    int dly = 0, hold = 0, o0, t0, v0, n;
    logic exp_ovf;

    // Emulates the slow UART side: acknowledges an offered byte after a short random delay.
    task automatic uart_step();
        if (tx_busy_sync) begin
            if (hold == 0) tx_busy_sync = 1'b0;
            else hold--;
        end else if (tx_d_vld) begin
            if (dly == 0) begin
                tx_busy_sync = 1'b1;
                hold = int'($urandom_range(0, 3));
                dly  = int'($urandom_range(0, 4));
            end else dly--;
        end
    endtask

    // Reference: ordered list of queued bytes; pushes judged on occupancy before the edge.
    task automatic model_step();
        int sz = q.size();
        exp_ovf = 1'b0;
        if (wr_word_en) begin
            if (sz <= DEPTH - 2) begin
                q.push_back(wr_word[7:0]);
                q.push_back(wr_word[15:8]);
            end else exp_ovf = 1'b1;
            if (wr_en) exp_ovf = 1'b1;
        end else if (wr_en) begin
            if (sz < DEPTH) q.push_back(wr_data);
            else exp_ovf = 1'b1;
        end
        if (tx_d_vld && tx_busy_sync) void'(q.pop_front());
    endtask

    task automatic model_check();
        check("rnd_count", 32'(count), 32'(q.size()));
        check("rnd_empty", 32'(empty), 32'(q.size() == 0));
        check("rnd_ovf", 32'(ovf_err), 32'(exp_ovf));
        check("rnd_to", 32'(to_err), 32'd0);
        if (tx_d_vld) begin
            check("rnd_vld_nonempty", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) check("rnd_data", 32'(tx_p_data), 32'(q[0]));
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_vld", 32'(tx_d_vld), 32'd0);
        check("rst_data", 32'(tx_p_data), 32'd0);
        check("rst_ovf", 32'(ovf_err), 32'd0);
        check("rst_to", 32'(to_err), 32'd0);
        RST = 1'b0;
        tick();

        // Single byte: valid two cycles after the push, ack drops it one edge later
        wr_data = 8'hA5;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("sb_count1", 32'(count), 32'd1);
        check("sb_vld_early", 32'(tx_d_vld), 32'd0);
        tick();
        check("sb_vld", 32'(tx_d_vld), 32'd1);
        check("sb_data", 32'(tx_p_data), 32'hA5);
        tx_busy_sync = 1'b1;
        tick();
        check("sb_ack_vld", 32'(tx_d_vld), 32'd0);
        check("sb_count0", 32'(count), 32'd0);
        check("sb_data_kept", 32'(tx_p_data), 32'hA5);
        repeat (19) tick();
        check("sb_busy_hold", 32'(tx_d_vld), 32'd0);
        tx_busy_sync = 1'b0;
        tick();
        tick();
        check("sb_empty", 32'(empty), 32'd1);
        check("sb_idle_vld", 32'(tx_d_vld), 32'd0);

        // Word split LSB first
        wr_word = 16'h1234;
        wr_word_en = 1'b1;
        tick();
        wr_word_en = 1'b0;
        check("w_count", 32'(count), 32'd2);
        handshake(8'h34, "w_lo");
        handshake(8'h12, "w_hi");
        check("w_empty", 32'(empty), 32'd1);

        // Full and overflow
        tx_busy_sync = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data = 8'(8'h40 + i);
            tick();
        end
        check("f_count8", 32'(count), 32'd8);
        check("f_full", 32'(full), 32'd1);
        check("f_ovf_pre", 32'(ovf_err), 32'd0);
        wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        check("f_ovf", 32'(ovf_err), 32'd1);
        check("f_count_keep", 32'(count), 32'd8);
        tick();
        check("f_ovf_pulse", 32'(ovf_err), 32'd0);
        tx_busy_sync = 1'b0;
        tick();
        check("f_head_vld", 32'(tx_d_vld), 32'd1);
        check("f_head_data", 32'(tx_p_data), 32'h40);
        tx_busy_sync = 1'b1;
        tick();
        check("f_count7", 32'(count), 32'd7);
        wr_word = 16'hBEEF;
        wr_word_en = 1'b1;
        tick();
        wr_word_en = 1'b0;
        check("f_word_ovf", 32'(ovf_err), 32'd1);
        check("f_word_count", 32'(count), 32'd7);
        tx_busy_sync = 1'b0;
        for (int i = 1; i < DEPTH; i++) handshake(8'(8'h40 + i), "f_drain");
        check("f_empty", 32'(empty), 32'd1);

        // Wrap-around with sequential bytes
        o0 = ovf_seen;
        t0 = to_seen;
        for (int i = 0; i < 20; i++) begin
            wr_data = 8'(i);
            wr_en = 1'b1;
            tick();
            wr_en = 1'b0;
            handshake(8'(i), "wrap");
        end
        check("wrap_empty", 32'(empty), 32'd1);
        check("wrap_no_ovf", 32'(ovf_seen - o0), 32'd0);
        check("wrap_no_to", 32'(to_seen - t0), 32'd0);

        // Timeout: busy never rises
        v0 = vld_cycles;
        t0 = to_seen;
        wr_data = 8'h5A;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        n = 0;
        while (!tx_d_vld && n < 10) begin tick(); n++; end
        check("to_vld", 32'(tx_d_vld), 32'd1);
        check("to_data", 32'(tx_p_data), 32'h5A);
        n = 0;
        while (tx_d_vld && n < 40) begin tick(); n++; end
        check("to_vld_fall", 32'(tx_d_vld), 32'd0);
        check("to_err", 32'(to_err), 32'd1);
        check("to_count", 32'(count), 32'd0);
        check("to_vld_len", 32'(vld_cycles - v0), 32'(TO + 1));
        tick();
        check("to_err_pulse", 32'(to_err), 32'd0);
        check("to_err_once", 32'(to_seen - t0), 32'd1);

        // Randomized traffic against the reference list
        q.delete();
        for (int c = 0; c < 400; c++) begin
            wr_en = ($urandom_range(0, 9) < 4);
            wr_word_en = ($urandom_range(0, 9) < 2);
            wr_data = 8'($urandom);
            wr_word = 16'($urandom);
            uart_step();
            model_step();
            tick();
            model_check();
        end
        wr_en = 1'b0;
        wr_word_en = 1'b0;
        n = 0;
        while ((q.size() > 0 || tx_busy_sync) && n < 400) begin
            uart_step();
            model_step();
            tick();
            model_check();
            n++;
        end
        check("rnd_drained", 32'(q.size()), 32'd0);
        tx_busy_sync = 1'b0;
        tick();
        tick();
        check("rnd_final_empty", 32'(empty), 32'd1);

        // Reset during SEND
        wr_data = 8'hC3;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
        check("rs_vld", 32'(tx_d_vld), 32'd1);
        #2 RST = 1'b1;
        #1;
        check("rs_vld_async", 32'(tx_d_vld), 32'd0);
        check("rs_count", 32'(count), 32'd0);
        check("rs_empty", 32'(empty), 32'd1);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rs_no_vld", 32'(tx_d_vld), 32'd0);
        end
        wr_data = 8'h3C;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        handshake(8'h3C, "rs_after");
        check("rs_end_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
